// File: rtl/ysyx_23060208_dsram_pkg.sv
// Shared constants and FSM encodings for the data-side SRAM responder.
// Response codes, store-size strobes and the byte-lane decode helper.
package ysyx_23060208_dsram_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam logic [2:0] WSTRB_W = 3'b100;
   localparam logic [2:0] WSTRB_H = 3'b010;
   localparam logic [2:0] WSTRB_B = 3'b001;

   typedef enum logic [2:0] {
      R_IDLE = 3'b001,
      R_WAIT = 3'b010,
      R_RESP = 3'b100
   } rd_state_e;

   typedef enum logic [2:0] {
      W_IDLE = 3'b001,
      W_WAIT = 3'b010,
      W_RESP = 3'b100
   } wr_state_e;

   // Byte enables for a store; zero means the strobe is illegal.
   function automatic logic [3:0] lane_be(
      input logic [2:0] strb,
      input logic [1:0] off
   );
      logic [3:0] be;
      be = 4'b0000;
      unique case (strb)
         WSTRB_W: be = 4'b1111;
         WSTRB_H: be = off[1] ? 4'b1100 : 4'b0011;
         WSTRB_B: be = 4'b0001 << off;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ysyx_23060208_dsram_array.sv
// Word-addressed storage: one byte-enabled write port, async read port.
// No reset, so contents survive a reset of the control logic.
module ysyx_23060208_dsram_array #(
   parameter int DEPTH = 16384,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // Byte-lane write on the commit edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_be[i]) begin
            r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_23060208_dsram.sv
// Data-side SRAM slave: independent read and write FSMs with latency.
// Loads return right-aligned data; stores apply the size strobe.
module ysyx_23060208_dsram
   import ysyx_23060208_dsram_pkg::*;
#(
   parameter int                DATA_WIDTH  = 32,
   parameter int                DEPTH_WORDS = 16384,
   parameter logic [31:0]       BASE_ADDR   = 32'h8000_0000,
   parameter int                RD_LAT      = 2,
   parameter int                WR_LAT      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] dsram_awaddr,
   input  logic                  dsram_awvalid,
   output logic                  dsram_awready,
   input  logic [DATA_WIDTH-1:0] dsram_wdata,
   input  logic [2:0]            dsram_wstrb,
   input  logic                  dsram_wvalid,
   output logic                  dsram_wready,
   output logic [1:0]            dsram_bresp,
   output logic                  dsram_bvalid,
   input  logic                  dsram_bready,
   input  logic [DATA_WIDTH-1:0] dsram_araddr,
   input  logic                  dsram_arvalid,
   output logic                  dsram_arready,
   output logic [DATA_WIDTH-1:0] dsram_rdata,
   output logic [1:0]            dsram_rresp,
   output logic                  dsram_rvalid,
   input  logic                  dsram_rready
);

   localparam int IW = $clog2(DEPTH_WORDS);

   rd_state_e r_rd_state, w_rd_next;
   wr_state_e r_wr_state, w_wr_next;

   logic                  r_live;
   logic [7:0]            r_rd_cnt, r_wr_cnt;
   logic [DATA_WIDTH-1:0] r_araddr, r_awaddr, r_wdata;
   logic [2:0]            r_wstrb;
   logic                  r_aw_got, r_w_got;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp, r_bresp;

   logic [31:0]           w_rd_word, w_wr_word;
   logic                  w_rd_ok, w_wr_ok, w_wr_err;
   logic [31:0]           w_mem_rdata, w_lane_data;
   logic [3:0]            w_lane_be, w_arr_be;
   logic                  w_arready, w_rvalid;
   logic                  w_awready, w_wready, w_bvalid;
   logic                  w_aw_hs, w_w_hs, w_both, w_commit;

   assign w_rd_word = (r_araddr - BASE_ADDR) >> 2;
   assign w_wr_word = (r_awaddr - BASE_ADDR) >> 2;
   assign w_rd_ok   = (r_araddr >= BASE_ADDR)
                    && (w_rd_word < 32'(DEPTH_WORDS));
   assign w_wr_ok   = (r_awaddr >= BASE_ADDR)
                    && (w_wr_word < 32'(DEPTH_WORDS));

   assign w_lane_be = lane_be(r_wstrb, r_awaddr[1:0]);
   assign w_wr_err  = !w_wr_ok || (w_lane_be == 4'b0000);

   // Replicate store data so every enabled lane sees its bytes.
   always_comb begin
      w_lane_data = r_wdata;
      unique case (r_wstrb)
         WSTRB_H: w_lane_data = {2{r_wdata[15:0]}};
         WSTRB_B: w_lane_data = {4{r_wdata[7:0]}};
         default: w_lane_data = r_wdata;
      endcase
   end

   assign w_commit = (r_wr_state == W_WAIT) && (r_wr_cnt == 8'd1);
   assign w_arr_be = (w_commit && !w_wr_err) ? w_lane_be : 4'b0000;

   ysyx_23060208_dsram_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (IW)
   ) u_array (
      .clk     (clk),
      .i_be    (w_arr_be),
      .i_waddr (w_wr_word[IW-1:0]),
      .i_wdata (w_lane_data),
      .i_raddr (w_rd_word[IW-1:0]),
      .o_rdata (w_mem_rdata)
   );

   // Readies stay low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_live <= 1'b0;
      else      r_live <= 1'b1;
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rd_state <= R_IDLE;
      else      r_rd_state <= w_rd_next;
   end

   // Read FSM next state and handshake outputs.
   always_comb begin
      w_rd_next = r_rd_state;
      w_arready = 1'b0;
      w_rvalid  = 1'b0;
      unique case (r_rd_state)
         R_IDLE: begin
            w_arready = r_live;
            if (dsram_arvalid && r_live) w_rd_next = R_WAIT;
         end
         R_WAIT: begin
            if (r_rd_cnt == 8'd1) w_rd_next = R_RESP;
         end
         R_RESP: begin
            w_rvalid = 1'b1;
            if (dsram_rready) w_rd_next = R_IDLE;
         end
         default: w_rd_next = R_IDLE;
      endcase
   end

   // Read address latch, latency counter and response capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_araddr <= '0;
         r_rd_cnt <= '0;
         r_rdata  <= '0;
         r_rresp  <= OKAY;
      end else if (r_rd_state == R_IDLE) begin
         if (dsram_arvalid && w_arready) begin
            r_araddr <= dsram_araddr;
            r_rd_cnt <= 8'(RD_LAT);
         end
      end else if (r_rd_state == R_WAIT) begin
         if (r_rd_cnt == 8'd1) begin
            r_rdata <= w_rd_ok
                     ? (w_mem_rdata >> {r_araddr[1:0], 3'b000})
                     : '0;
            r_rresp <= w_rd_ok ? OKAY : SLVERR;
         end else begin
            r_rd_cnt <= r_rd_cnt - 8'd1;
         end
      end
   end

   assign w_awready = r_live && (r_wr_state == W_IDLE) && !r_aw_got;
   assign w_wready  = r_live && (r_wr_state == W_IDLE) && !r_w_got;
   assign w_aw_hs   = dsram_awvalid && w_awready;
   assign w_w_hs    = dsram_wvalid && w_wready;
   assign w_both    = (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

   // Write FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_wr_state <= W_IDLE;
      else      r_wr_state <= w_wr_next;
   end

   // Write FSM next state and response valid.
   always_comb begin
      w_wr_next = r_wr_state;
      w_bvalid  = 1'b0;
      unique case (r_wr_state)
         W_IDLE: if (w_both) w_wr_next = W_WAIT;
         W_WAIT: if (r_wr_cnt == 8'd1) w_wr_next = W_RESP;
         W_RESP: begin
            w_bvalid = 1'b1;
            if (dsram_bready) w_wr_next = W_IDLE;
         end
         default: w_wr_next = W_IDLE;
      endcase
   end

   // Independent AW/W capture, latency counter and response code.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_wr_cnt <= '0;
         r_bresp  <= OKAY;
      end else if (r_wr_state == W_IDLE) begin
         if (w_aw_hs) begin
            r_awaddr <= dsram_awaddr;
            r_aw_got <= 1'b1;
         end
         if (w_w_hs) begin
            r_wdata <= dsram_wdata;
            r_wstrb <= dsram_wstrb;
            r_w_got <= 1'b1;
         end
         if (w_both) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_wr_cnt <= 8'(WR_LAT);
         end
      end else if (r_wr_state == W_WAIT) begin
         if (r_wr_cnt == 8'd1) begin
            r_bresp <= w_wr_err ? SLVERR : OKAY;
         end else begin
            r_wr_cnt <= r_wr_cnt - 8'd1;
         end
      end
   end

   assign dsram_arready = w_arready;
   assign dsram_rvalid  = w_rvalid;
   assign dsram_rdata   = r_rdata;
   assign dsram_rresp   = r_rresp;
   assign dsram_awready = w_awready;
   assign dsram_wready  = w_wready;
   assign dsram_bvalid  = w_bvalid;
   assign dsram_bresp   = r_bresp;

endmodule
